periph_bus_arbiter: RTL and testbench

PERIPH_BUS_ARBITER -- requirements
Module: periph_bus_arbiter

---
 rtl/periph_bus_arbiter_pkg.sv | 14 +
 rtl/periph_bus_arbiter.sv | 101 ++++++++++
 tb/tb_periph_bus_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/periph_bus_arbiter_pkg.sv
// Shared definitions for the two-master peripheral bus arbiter:
// FSM state encoding and master index constants.
package periph_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

endpackage

// File: rtl/periph_bus_arbiter.sv
// Round-robin arbiter sharing one peripheral slave port between two masters.
// Each transaction takes three cycles: IDLE (arbitrate), ACCESS (slave cycle), RESP (ack).
module periph_bus_arbiter
    import periph_bus_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [DATA_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [DATA_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              s_we,
    output logic [DATA_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    output logic              busy,
    output logic              grant_id
);

    state_t            state;
    state_t            state_next;
    logic              winner;
    logic              win_we;
    logic [DATA_W-1:0] win_addr;
    logic [DATA_W-1:0] win_wdata;
    logic              lat_we;
    logic [DATA_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [DATA_W-1:0] rd_reg;
    logic              grant_q;
    logic              last_grant;

    // On a tie the master that was not granted last time wins.
    always_comb begin
        winner = M0;
        if (m0_req && m1_req) begin
            winner = (last_grant == M0) ? M1 : M0;
        end else if (m1_req) begin
            winner = M1;
        end
        win_we    = (winner == M1) ? m1_we    : m0_we;
        win_addr  = (winner == M1) ? m1_addr  : m0_addr;
        win_wdata = (winner == M1) ? m1_wdata : m0_wdata;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (m0_req || m1_req) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rd_reg     <= '0;
            grant_q    <= M0;
            last_grant <= M1;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == ACCESS) begin
                lat_we     <= win_we;
                lat_addr   <= win_addr;
                lat_wdata  <= win_wdata;
                grant_q    <= winner;
                last_grant <= winner;
            end
            if (state == ACCESS) begin
                rd_reg <= lat_we ? '0 : s_rdata;
            end
        end
    end

    // Address and write data simply hold the last latched values outside ACCESS.
    assign s_we     = (state == ACCESS) && lat_we;
    assign s_addr   = lat_addr;
    assign s_wdata  = lat_wdata;
    assign busy     = (state != IDLE);
    assign grant_id = grant_q;
    assign m0_ack   = (state == RESP) && (grant_q == M0);
    assign m1_ack   = (state == RESP) && (grant_q == M1);
    assign m0_rdata = m0_ack ? rd_reg : '0;
    assign m1_rdata = m1_ack ? rd_reg : '0;

endmodule

// File: tb/tb_periph_bus_arbiter.sv
// Directed self-checking bench for periph_bus_arbiter: single transactions,
// round-robin ties, input changes after latch, and reset mid-transaction.
module tb_periph_bus_arbiter;

    localparam int DATA_W = 32;

    logic              clk;
    logic              rst_n;
    logic              m0_req, m0_we, m1_req, m1_we;
    logic [DATA_W-1:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic              m0_ack, m1_ack, s_we, busy, grant_id;
    logic [DATA_W-1:0] m0_rdata, m1_rdata, s_addr, s_wdata, s_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    periph_bus_arbiter #(.DATA_W(DATA_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wdata (m0_wdata),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wdata (m1_wdata),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .s_we     (s_we),
        .s_addr   (s_addr),
        .s_wdata  (s_wdata),
        .s_rdata  (s_rdata),
        .busy     (busy),
        .grant_id (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [DATA_W-1:0] obs,
                                input logic [DATA_W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, " s_we"},     32'(s_we),     32'h0);
        check_output({tag, " s_addr"},   s_addr,        32'h0);
        check_output({tag, " s_wdata"},  s_wdata,       32'h0);
        check_output({tag, " m0_ack"},   32'(m0_ack),   32'h0);
        check_output({tag, " m1_ack"},   32'(m1_ack),   32'h0);
        check_output({tag, " m0_rdata"}, m0_rdata,      32'h0);
        check_output({tag, " m1_rdata"}, m1_rdata,      32'h0);
        check_output({tag, " busy"},     32'(busy),     32'h0);
        check_output({tag, " grant_id"}, 32'(grant_id), 32'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int phase;
        int txn;
        logic exp_gnt;
        s_rdata = '0;

        // Reset state
        do_reset();
        @(negedge clk);
        check_reset_values("reset");

        // m0 write addr 0x0 wdata 0x5; address changes during ACCESS must not leak
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0; m0_wdata = 32'h5;
        @(negedge clk);
        check_output("wr access s_we",     32'(s_we),     32'h1);
        check_output("wr access s_addr",   s_addr,        32'h0);
        check_output("wr access s_wdata",  s_wdata,       32'h5);
        check_output("wr access busy",     32'(busy),     32'h1);
        check_output("wr access grant_id", 32'(grant_id), 32'h0);
        check_output("wr access m0_ack",   32'(m0_ack),   32'h0);
        m0_addr = 32'h4; m0_wdata = 32'h9;
        @(negedge clk);
        check_output("wr resp m0_ack",   32'(m0_ack), 32'h1);
        check_output("wr resp m1_ack",   32'(m1_ack), 32'h0);
        check_output("wr resp s_we",     32'(s_we),   32'h0);
        check_output("wr resp s_addr",   s_addr,      32'h0);
        check_output("wr resp s_wdata",  s_wdata,     32'h5);
        check_output("wr resp m0_rdata", m0_rdata,    32'h0);
        m0_req = 1'b0;
        @(negedge clk);
        check_output("wr idle busy",   32'(busy),   32'h0);
        check_output("wr idle m0_ack", 32'(m0_ack), 32'h0);
        @(negedge clk);
        check_output("no req busy", 32'(busy), 32'h0);

        // m1 read addr 0x4, slave returns 0xA5A5_0003 during ACCESS only
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h4; m1_wdata = 32'h77;
        @(negedge clk);
        check_output("rd access s_we",     32'(s_we),     32'h0);
        check_output("rd access s_addr",   s_addr,        32'h4);
        check_output("rd access grant_id", 32'(grant_id), 32'h1);
        s_rdata = 32'hA5A5_0003;
        @(negedge clk);
        s_rdata = 32'hDEAD_BEEF;
        #1;
        check_output("rd resp m1_ack",   32'(m1_ack), 32'h1);
        check_output("rd resp m1_rdata", m1_rdata,    32'hA5A5_0003);
        check_output("rd resp m0_ack",   32'(m0_ack), 32'h0);
        check_output("rd resp m0_rdata", m0_rdata,    32'h0);
        check_output("rd resp s_we",     32'(s_we),   32'h0);
        m1_req = 1'b0;
        @(negedge clk);
        check_output("rd idle m1_rdata", m1_rdata, 32'h0);

        // Both request right after reset: m0 first, then strict alternation
        do_reset();
        s_rdata = 32'h0000_1234;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h10; m0_wdata = 32'hAA;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20; m1_wdata = 32'hBB;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            phase   = (k - 1) % 3;
            txn     = (k - 1) / 3;
            exp_gnt = (txn % 2) == 1;
            if (k == 12) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            check_output($sformatf("rr c%0d busy", k), 32'(busy), (phase == 2) ? 32'h0 : 32'h1);
            check_output($sformatf("rr c%0d m0_ack", k), 32'(m0_ack),
                         (phase == 1 && !exp_gnt) ? 32'h1 : 32'h0);
            check_output($sformatf("rr c%0d m1_ack", k), 32'(m1_ack),
                         (phase == 1 && exp_gnt) ? 32'h1 : 32'h0);
            if (phase == 0) begin
                check_output($sformatf("rr c%0d grant_id", k), 32'(grant_id), 32'(exp_gnt));
                check_output($sformatf("rr c%0d s_addr", k), s_addr, exp_gnt ? 32'h20 : 32'h10);
                check_output($sformatf("rr c%0d s_we", k), 32'(s_we), exp_gnt ? 32'h0 : 32'h1);
            end
            if (phase == 1 && exp_gnt) begin
                check_output($sformatf("rr c%0d m1_rdata", k), m1_rdata, 32'h0000_1234);
            end
        end
        @(negedge clk);
        check_output("rr drained busy", 32'(busy), 32'h0);

        // Reset during ACCESS of an m0 write aborts it
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h8; m0_wdata = 32'h7;
        @(negedge clk);
        check_output("abort access s_we",   32'(s_we), 32'h1);
        check_output("abort access s_addr", s_addr,    32'h8);
        rst_n = 1'b0;
        m0_req = 1'b0;
        @(negedge clk);
        check_reset_values("abort");
        rst_n = 1'b1;
        @(negedge clk);
        check_output("abort after m0_ack", 32'(m0_ack), 32'h0);
        check_output("abort after busy",   32'(busy),   32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
